// File: rtl/mult_sequencer_pkg.sv
// Shared types and defaults for the multi-cycle LEGv8 MUL sequencer.
// The state encoding is fixed so the FSM state reads the same in debug dumps.
package mult_sequencer_pkg;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'b00,
        MULT_RUN  = 2'b01,
        MULT_DONE = 2'b10
    } mult_state_e;

    localparam int MULT_WIDTH          = 64;
    localparam int MULT_BITS_PER_CYCLE = 1;

    // Number of shift-add iterations needed to retire every multiplier bit.
    function automatic int mult_iters(input int width, input int bpc);
        return width / bpc;
    endfunction

endpackage

// File: rtl/mult_sequencer_step.sv
// One shift-add multiply iteration: retires BITS_PER_CYCLE multiplier bits.
module mult_step #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic [WIDTH-1:0] o_next_acc,
    output logic [WIDTH-1:0] o_next_mcand,
    output logic [WIDTH-1:0] o_next_mplier,
    output logic             o_mplier_zero
);

    logic [WIDTH-1:0] w_sum;

    // Partial products as shifted adds, so no hardware multiplier is inferred.
    always_comb begin
        w_sum = i_acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (i_mplier[i]) begin
                w_sum = w_sum + (i_mcand << i);
            end else begin
                w_sum = w_sum;
            end
        end
    end

    assign o_next_acc    = w_sum;
    assign o_next_mcand  = i_mcand << BITS_PER_CYCLE;
    assign o_next_mplier = i_mplier >> BITS_PER_CYCLE;
    assign o_mplier_zero = (o_next_mplier == {WIDTH{1'b0}});

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle MUL sequencer: IDLE/RUN/DONE FSM, iteration counter and
// operand registers around a single combinational mult_step.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH          = MULT_WIDTH,
    parameter int BITS_PER_CYCLE = MULT_BITS_PER_CYCLE,
    parameter bit EARLY_EXIT     = 1'b1,
    localparam int CW            = $clog2(WIDTH / BITS_PER_CYCLE) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    iter_count
);

    localparam logic [CW-1:0] N_ITERS = CW'(mult_iters(WIDTH, BITS_PER_CYCLE));

    mult_state_e      r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;

    logic [WIDTH-1:0] w_next_acc;
    logic [WIDTH-1:0] w_next_mcand;
    logic [WIDTH-1:0] w_next_mplier;
    logic             w_mplier_zero;
    logic [CW-1:0]    w_iter_next;
    logic             w_finish;

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_acc         (r_acc),
        .i_mcand       (r_mcand),
        .i_mplier      (r_mplier),
        .o_next_acc    (w_next_acc),
        .o_next_mcand  (w_next_mcand),
        .o_next_mplier (w_next_mplier),
        .o_mplier_zero (w_mplier_zero)
    );

    assign w_iter_next = iter_count + {{(CW-1){1'b0}}, 1'b1};
    assign w_finish    = (w_iter_next == N_ITERS) || (EARLY_EXIT && w_mplier_zero);

    // FSM, datapath registers and registered status outputs; abort overrides all states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MULT_IDLE;
            r_acc      <= {WIDTH{1'b0}};
            r_mcand    <= {WIDTH{1'b0}};
            r_mplier   <= {WIDTH{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= {WIDTH{1'b0}};
            iter_count <= {CW{1'b0}};
        end else if (abort) begin
            r_state <= MULT_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                MULT_IDLE: begin
                    if (start) begin
                        r_state    <= MULT_RUN;
                        r_acc      <= {WIDTH{1'b0}};
                        r_mcand    <= op_a;
                        r_mplier   <= op_b;
                        iter_count <= {CW{1'b0}};
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b0;
                    end
                end
                MULT_RUN: begin
                    r_acc      <= w_next_acc;
                    r_mcand    <= w_next_mcand;
                    r_mplier   <= w_next_mplier;
                    iter_count <= w_iter_next;
                    busy       <= 1'b1;
                    if (w_finish) begin
                        r_state <= MULT_DONE;
                        result  <= w_next_acc;
                        done    <= 1'b1;
                    end else begin
                        done <= 1'b0;
                    end
                end
                MULT_DONE: begin
                    r_state <= MULT_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= MULT_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench: four sequencer configurations checked against an
// arithmetic reference (a*b mod 2^64 and the expected iteration count).
module tb_mult_sequencer;

    localparam int NDUT = 4;
    localparam int BPC_T [NDUT] = '{1, 1, 4, 2};
    localparam bit EE_T  [NDUT] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic        clk;
    logic        rst_n;
    logic        start_a [NDUT];
    logic        abort_a [NDUT];
    logic [63:0] opa_a   [NDUT];
    logic [63:0] opb_a   [NDUT];
    logic        busy_a  [NDUT];
    logic        done_a  [NDUT];
    logic [63:0] res_a   [NDUT];
    logic [6:0]  itc_a   [NDUT];
    logic [6:0]  itc0, itc1;
    logic [4:0]  itc2;
    logic [5:0]  itc3;

    int n_pass  = 0;
    int n_total = 0;

    mult_sequencer #(.WIDTH(64), .BITS_PER_CYCLE(1), .EARLY_EXIT(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .abort(abort_a[0]),
        .op_a(opa_a[0]), .op_b(opb_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .result(res_a[0]), .iter_count(itc0));
    mult_sequencer #(.WIDTH(64), .BITS_PER_CYCLE(1), .EARLY_EXIT(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .abort(abort_a[1]),
        .op_a(opa_a[1]), .op_b(opb_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .result(res_a[1]), .iter_count(itc1));
    mult_sequencer #(.WIDTH(64), .BITS_PER_CYCLE(4), .EARLY_EXIT(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .abort(abort_a[2]),
        .op_a(opa_a[2]), .op_b(opb_a[2]), .busy(busy_a[2]), .done(done_a[2]),
        .result(res_a[2]), .iter_count(itc2));
    mult_sequencer #(.WIDTH(64), .BITS_PER_CYCLE(2), .EARLY_EXIT(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_a[3]), .abort(abort_a[3]),
        .op_a(opa_a[3]), .op_b(opb_a[3]), .busy(busy_a[3]), .done(done_a[3]),
        .result(res_a[3]), .iter_count(itc3));

    assign itc_a[0] = itc0;
    assign itc_a[1] = itc1;
    assign itc_a[2] = {2'b00, itc2};
    assign itc_a[3] = {1'b0, itc3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected number of iterations, straight from the latency rule.
    function automatic int exp_k(input int bpc, input bit ee, input logic [63:0] b);
        int msb;
        if (!ee) return 64 / bpc;
        msb = -1;
        for (int i = 0; i < 64; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + bpc) / bpc;
    endfunction

    // Starts an operation from the current negedge (DUT in IDLE) and checks
    // result, latency, iteration count and busy window. Ends on an IDLE negedge.
    task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b, input string tag);
        int k;
        int cyc;
        int busy_cyc;
        logic [63:0] prod;
        logic [63:0] a_hold;
        logic [63:0] b_hold;
        k    = exp_k(BPC_T[d], EE_T[d], b);
        prod = a * b;
        start_a[d] = 1'b1;
        opa_a[d]   = a;
        opb_a[d]   = b;
        @(negedge clk);
        start_a[d] = 1'b0;
        a_hold     = $urandom();
        b_hold     = $urandom();
        opa_a[d]   = a_hold;
        opb_a[d]   = b_hold;
        cyc      = 0;
        busy_cyc = 0;
        while (!done_a[d] && cyc < 200) begin
            if (busy_a[d]) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        if (busy_a[d]) busy_cyc++;
        chk({tag, "_latency"}, 64'(cyc), 64'(k));
        chk({tag, "_result"}, res_a[d], prod);
        chk({tag, "_iter"}, 64'(itc_a[d]), 64'(k));
        chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(k + 1));
        @(negedge clk);
        chk({tag, "_done_single"}, 64'(done_a[d]), 64'(0));
        chk({tag, "_busy_off"}, 64'(busy_a[d]), 64'(0));
        chk({tag, "_result_held"}, res_a[d], prod);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int d;
        int w;
        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            start_a[i] = 1'b0;
            abort_a[i] = 1'b0;
            opa_a[i]   = 64'd0;
            opb_a[i]   = 64'd0;
        end
        #12;
        for (int i = 0; i < NDUT; i++) begin
            chk("reset_busy", 64'(busy_a[i]), 64'(0));
            chk("reset_done", 64'(done_a[i]), 64'(0));
            chk("reset_result", res_a[i], 64'd0);
            chk("reset_iter", 64'(itc_a[i]), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1, 64'd7, 64'd6, "full64_7x6");
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, "early_wrap");
        run_op(0, 64'd123, 64'd0, "early_zero");
        run_op(0, 64'd5, 64'd5, "back_to_back");
        run_op(2, 64'h1_0000_0000, 64'h1_0000_0001, "bpc4_trunc");

        // Abort mid-run on the full-length configuration.
        run_op(1, 64'd5, 64'd5, "pre_abort");
        start_a[1] = 1'b1;
        opa_a[1]   = 64'd9;
        opb_a[1]   = 64'd9;
        @(negedge clk);
        start_a[1] = 1'b0;
        w = 0;
        while (itc_a[1] != 7'd10 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reach_iter10", 64'(itc_a[1]), 64'd10);
        abort_a[1] = 1'b1;
        @(negedge clk);
        abort_a[1] = 1'b0;
        chk("abort_busy", 64'(busy_a[1]), 64'(0));
        chk("abort_done", 64'(done_a[1]), 64'(0));
        chk("abort_result", res_a[1], 64'd25);
        w = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done_a[1] || busy_a[1]) w++;
        end
        chk("abort_no_pulse", 64'(w), 64'd0);
        start_a[1] = 1'b1;
        abort_a[1] = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        abort_a[1] = 1'b0;
        chk("abort_blocks_start", 64'(busy_a[1]), 64'(0));
        @(negedge clk);
        chk("abort_blocks_start2", 64'(busy_a[1]), 64'(0));

        // Randomized operations across all configurations.
        for (int n = 0; n < 16; n++) begin
            d  = n % NDUT;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if (n == 5) rb = 64'd0;
            run_op(d, ra, rb, "rand");
        end

        // Asynchronous reset in the middle of an operation.
        start_a[0] = 1'b1;
        opa_a[0]   = 64'hDEAD_BEEF_0123_4567;
        opb_a[0]   = 64'hFFFF_0000_0000_0000;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("prereset_busy", 64'(busy_a[0]), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy_a[0]), 64'(0));
        chk("async_rst_done", 64'(done_a[0]), 64'(0));
        chk("async_rst_result", res_a[0], 64'd0);
        chk("async_rst_iter", 64'(itc_a[0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 64'd3, 64'd4, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Multi-cycle sequencer and datapath for the LEGv8 MUL instruction in the non-pipelined core.
- Accepts the one-cycle start request raised by the decode control unit, together with both register operands.
- Iterates a shift-add multiply over several clocks, then returns a one-cycle done pulse and the low 64 bits of the product.
- While the sequencer runs, decode holds the PC (branch_op 110). On done, decode writes the result back and the PC advances.

Parameters:
- WIDTH, 64, operand and result width in bits.
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values are 1, 2 and 4. Must divide WIDTH.
- EARLY_EXIT, 1, when 1 the sequencer finishes as soon as the remaining multiplier bits are all zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request from decode (mult_start). Sampled only in IDLE.
- abort  in  1  cancels the operation in progress (pipeline flush or exception). Highest priority.
- op_a  in  WIDTH  multiplicand (Rn). Sampled only on an accepted start.
- op_b  in  WIDTH  multiplier (Rm). Sampled only on an accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  single-cycle pulse, high in DONE (multiplier_done).
- result  out  WIDTH  product mod 2^WIDTH. Registered; held until the next DONE.
- iter_count  out  $clog2(WIDTH/BITS_PER_CYCLE)+1  iterations completed in the current operation, for debug and perf.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; busy=0, done=0, result=0, iter_count=0; internal accumulator, multiplicand and multiplier registers all 0.
- Let N = WIDTH/BITS_PER_CYCLE.
- States are IDLE, RUN and DONE. busy = (state != IDLE); done = (state == DONE).
- IDLE:
  - start=1 and abort=0 → latch mcand=op_a, mplier=op_b, acc=0, iter_count=0; go to RUN.
  - Otherwise remain in IDLE.
- RUN, each rising edge:
  - acc ← (acc + mcand × mplier[BITS_PER_CYCLE-1:0]) mod 2^WIDTH.
  - mcand ← mcand << BITS_PER_CYCLE, dropping overflow.
  - mplier ← mplier >> BITS_PER_CYCLE, logical shift.
  - iter_count ← iter_count + 1.
  - Go to DONE when the updated iter_count == N, or when EARLY_EXIT=1 and the shifted mplier == 0.
  - On that same edge, result ← the updated acc.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE unconditionally.
  - start is ignored in DONE. Decode does not assert start while done=1.
  - A back-to-back MUL is accepted in the IDLE cycle that follows.
- Latency: the start edge is E0 and the edge that enters DONE is Ek.
  - Worst case k = N: 64 cycles at the defaults, 16 with BITS_PER_CYCLE=4.
  - With EARLY_EXIT=1, k = max(1, ceil(msb_index(op_b)+1 / BITS_PER_CYCLE)).
  - op_b=0 therefore gives k=1.
- Signedness: not relevant. The low WIDTH bits are identical for signed and unsigned operands, so no sign handling is required.
- abort:
  - In RUN or DONE, abort=1 → IDLE on the next edge.
  - done does not pulse after abort (an abort in DONE drops the pulse at the next edge). result keeps its previous value.
  - abort in IDLE blocks a simultaneous start.
- start while in RUN: ignored. Operands are not re-sampled.
- Operands are sampled only on the accepted start. Later changes on op_a/op_b have no effect.
- rst_n asserted mid-operation: immediate return to reset values; result clears to 0.

Decomposition:
- Add to constants.vh:
  - state encodings MULT_IDLE=2'b00, MULT_RUN=2'b01, MULT_DONE=2'b10;
  - the default MULT_BITS_PER_CYCLE.
  - 2'b11 is illegal and is decoded to IDLE.
- Sub-module mult_step (combinational):
  - inputs acc, mcand, mplier;
  - outputs next_acc, next_mcand, next_mplier, mplier_zero.
- The sequencer holds the FSM, the counter and the registers, and instantiates one mult_step.

Test Plan:
- Reset, then start with op_a=7, op_b=6, EARLY_EXIT=0, BITS_PER_CYCLE=1 → done pulses exactly 64 cycles after the start edge; result=42; busy high for 65 cycles; iter_count=64 in DONE.
- EARLY_EXIT=1, op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=3 → DONE entered on E2; result=0xFFFF_FFFF_FFFF_FFFD (wraps mod 2^64).
- EARLY_EXIT=1, op_b=0, op_a=123 → done on E1, result=0. Immediately start op_a=5, op_b=5 in the following IDLE cycle → second done, result=25.
- BITS_PER_CYCLE=4, EARLY_EXIT=0, op_a=0x1_0000_0000, op_b=0x1_0000_0001 → done after 16 iterations; result=0x1_0000_0000 (high product bits discarded).
- Start 9×9, then abort at iteration 10 → no done pulse; result keeps prior value 25; busy low the next cycle. A start in the same cycle as abort in IDLE is ignored.
- Deassert rst_n mid-RUN → busy, done, result and iter_count are 0 asynchronously. After release, a new 3×4 operation returns 12.
